neuron_layer_seq: RTL and testbench

- Sequences one shared `neuron` datapath across NUM_NEURONS outputs of a fully-connected layer.
- Per output neuron:
  - streams NUM_INPUTS activation/weight pairs from synchronous memories;
  - presents that neuron's bias;
  - waits for the neuron's result and writes it to the layer result buffer.
- Sits between the layer-level start/done handshake and the input/weight/bias memories.

---
 rtl/nn_pkg.sv | 21 ++
 rtl/seq_addr_gen.sv | 51 +++++
 rtl/neuron_layer_seq.sv | 150 +++++++++++++++
 tb/tb_neuron_layer_seq.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and helpers for the layer sequencer: FSM state encoding,
// default datapath width and an address-width helper.
package nn_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        STREAM,
        WAIT,
        WRITE,
        DONE
    } state_t;

    // Width of an index covering 0..n-1; never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_addr_gen.sv
// Input index i, neuron index j and the running weight address for the
// layer sequencer, with terminal-count flags for the FSM.
module seq_addr_gen
    import nn_pkg::*;
#(
    parameter int NUM_INPUTS  = 784,
    parameter int NUM_NEURONS = 10,
    localparam int IW = addr_w(NUM_INPUTS),
    localparam int JW = addr_w(NUM_NEURONS),
    localparam int WW = addr_w(NUM_INPUTS * NUM_NEURONS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          step_i,
    input  logic          step_j,
    output logic [IW-1:0] i,
    output logic [JW-1:0] j,
    output logic [WW-1:0] w_addr,
    output logic          i_last,
    output logic          j_last
);

    localparam logic [IW-1:0] I_LAST = IW'(NUM_INPUTS - 1);
    localparam logic [JW-1:0] J_LAST = JW'(NUM_NEURONS - 1);

    assign i_last = (i == I_LAST);
    assign j_last = (j == J_LAST);

    // Weight rows are contiguous, so a free-running increment yields
    // j*NUM_INPUTS+i without a multiplier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i      <= '0;
            j      <= '0;
            w_addr <= '0;
        end else if (clr) begin
            i      <= '0;
            j      <= '0;
            w_addr <= '0;
        end else begin
            if (step_i) begin
                i      <= i_last ? '0 : i + 1'b1;
                w_addr <= w_addr + 1'b1;
            end
            if (step_j)
                j <= j + 1'b1;
        end
    end

endmodule

// File: rtl/neuron_layer_seq.sv
// Time-multiplexes one neuron datapath over all outputs of a dense layer.
// Optional WAIT watchdog: define NEURON_LAYER_SEQ_WDOG_EN.
module neuron_layer_seq
    import nn_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int NUM_INPUTS  = 784,
    parameter int NUM_NEURONS = 10,
    parameter int WDOG_CYCLES = 16,
    localparam int IW = addr_w(NUM_INPUTS),
    localparam int JW = addr_w(NUM_NEURONS),
    localparam int WW = addr_w(NUM_INPUTS * NUM_NEURONS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [IW-1:0]     in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic [WW-1:0]     w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic [JW-1:0]     b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              neu_rst,
    output logic              neu_valid,
    output logic [DATA_W-1:0] neu_data,
    output logic [DATA_W-1:0] neu_weight,
    output logic [DATA_W-1:0] neu_bias,
    input  logic [DATA_W-1:0] neu_out,
    input  logic              neu_out_valid,
    output logic [JW-1:0]     res_addr,
    output logic [DATA_W-1:0] res_data,
    output logic              res_we
);

    state_t        state;
    logic [IW-1:0] i;
    logic [JW-1:0] j;
    logic          i_last;
    logic          j_last;

    assign neu_data   = in_data;
    assign neu_weight = w_data;
    assign neu_bias   = b_data;
    assign in_addr    = i;
    assign b_addr     = j;

    seq_addr_gen #(
        .NUM_INPUTS (NUM_INPUTS),
        .NUM_NEURONS(NUM_NEURONS)
    ) u_addr (
        .clk   (clk),
        .rst   (rst),
        .clr   (state == IDLE),
        .step_i(state == STREAM),
        .step_j((state == WRITE) && !j_last),
        .i     (i),
        .j     (j),
        .w_addr(w_addr),
        .i_last(i_last),
        .j_last(j_last)
    );

`ifdef NEURON_LAYER_SEQ_WDOG_EN
    localparam int WDW = addr_w(WDOG_CYCLES);
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(WDOG_CYCLES - 1);
    logic [WDW-1:0] wdog;
    logic           err_q;
    assign error = err_q;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            neu_rst   <= 1'b0;
            neu_valid <= 1'b0;
            res_we    <= 1'b0;
            res_addr  <= '0;
            res_data  <= '0;
`ifdef NEURON_LAYER_SEQ_WDOG_EN
            wdog      <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            done      <= 1'b0;
            neu_rst   <= 1'b0;
            res_we    <= 1'b0;
            // Delayed one cycle to line up with the memories' read latency.
            neu_valid <= (state == STREAM);
`ifdef NEURON_LAYER_SEQ_WDOG_EN
            wdog      <= '0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= INIT;
                        busy    <= 1'b1;
                        neu_rst <= 1'b1;
`ifdef NEURON_LAYER_SEQ_WDOG_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
                INIT: state <= STREAM;
                STREAM: begin
                    if (i_last)
                        state <= WAIT;
                end
                WAIT: begin
                    if (neu_out_valid) begin
                        res_we   <= 1'b1;
                        res_addr <= j;
                        res_data <= neu_out;
                        state    <= WRITE;
                    end
`ifdef NEURON_LAYER_SEQ_WDOG_EN
                    else if (wdog == WDOG_LAST) begin
                        // Abandon the rest of the layer but still close the handshake.
                        err_q <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
`endif
                end
                WRITE: begin
                    if (j_last) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= STREAM;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_layer_seq.sv
// Directed bench for neuron_layer_seq with a small Q4.12 ReLU neuron model
// and 1-cycle-latency activation/weight/bias memories.
module tb_neuron_layer_seq;

    localparam int NI = 4;
    localparam int NN = 3;
    localparam int DW = 16;
    localparam int WD = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          error;
    logic [1:0]    in_addr;
    logic [DW-1:0] in_data;
    logic [3:0]    w_addr;
    logic [DW-1:0] w_data;
    logic [1:0]    b_addr;
    logic [DW-1:0] b_data;
    logic          neu_rst;
    logic          neu_valid;
    logic [DW-1:0] neu_data;
    logic [DW-1:0] neu_weight;
    logic [DW-1:0] neu_bias;
    logic [DW-1:0] neu_out;
    logic          neu_out_valid;
    logic [1:0]    res_addr;
    logic [DW-1:0] res_data;
    logic          res_we;

    neuron_layer_seq #(
        .DATA_W     (DW),
        .NUM_INPUTS (NI),
        .NUM_NEURONS(NN),
        .WDOG_CYCLES(WD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .in_addr      (in_addr),
        .in_data      (in_data),
        .w_addr       (w_addr),
        .w_data       (w_data),
        .b_addr       (b_addr),
        .b_data       (b_data),
        .neu_rst      (neu_rst),
        .neu_valid    (neu_valid),
        .neu_data     (neu_data),
        .neu_weight   (neu_weight),
        .neu_bias     (neu_bias),
        .neu_out      (neu_out),
        .neu_out_valid(neu_out_valid),
        .res_addr     (res_addr),
        .res_data     (res_data),
        .res_we       (res_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] act_mem [0:3];
    logic [DW-1:0] w_mem   [0:15];
    logic [DW-1:0] b_mem   [0:3];

    always @(posedge clk) begin
        in_data <= act_mem[in_addr];
        w_data  <= w_mem[w_addr];
        b_data  <= b_mem[b_addr];
    end

    // Neuron model: Q4.12 MAC, result presented combinationally on the final pair.
    int acc, pcnt, prod, sum;
    bit quiet;

    always @(posedge clk) begin
        if (neu_rst) begin
            acc  <= 0;
            pcnt <= 0;
        end else if (neu_valid) begin
            if (pcnt == NI - 1) begin
                acc  <= 0;
                pcnt <= 0;
            end else begin
                acc  <= acc + prod;
                pcnt <= pcnt + 1;
            end
        end
    end

    always_comb begin
        prod = (int'($signed(neu_data)) * int'($signed(neu_weight))) >>> 12;
        sum  = acc + prod + int'($signed(neu_bias));
        neu_out = '0;
        if (sum > 32767)
            neu_out = 16'h7fff;
        else if (sum > 0)
            neu_out = sum[15:0];
        neu_out_valid = neu_valid && (pcnt == NI - 1) && !quiet;
    end

    // Monitors: result writes, done pulses, and the addresses behind each pair.
    int unsigned ra_q[$], rd_q[$], ia_q[$], wa_q[$], ba_q[$];
    int done_cnt;
    logic [1:0] p_in, p_b;
    logic [3:0] p_w;

    initial done_cnt = 0;

    always @(negedge clk) begin
        if (res_we) begin
            ra_q.push_back(res_addr);
            rd_q.push_back(res_data);
        end
        if (done)
            done_cnt <= done_cnt + 1;
        if (neu_valid) begin
            ia_q.push_back(p_in);
            wa_q.push_back(p_w);
            ba_q.push_back(p_b);
        end
        p_in <= in_addr;
        p_w  <= w_addr;
        p_b  <= b_addr;
    end

    int n_cmp, n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {busy, done, error, neu_rst, neu_valid, res_we,
                in_addr, w_addr, b_addr, res_addr, res_data};
    endfunction

    // Start a layer; done_edge/busy_last are edge numbers relative to the start edge.
    task automatic run_layer(input bit hold, output int done_edge, output int busy_last);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        done_edge = -1;
        busy_last = busy ? 0 : -1;
        for (int n = 1; n < 300; n++) begin
            @(posedge clk);
            #1;
            if (busy) busy_last = n;
            if (done && done_edge < 0) begin
                done_edge = n;
                start = 1'b0;
            end
            if (done_edge >= 0 && n >= done_edge + 4) break;
        end
    endtask

    task automatic check_results(input string tag, input int base, input int unsigned d0,
                                 input int unsigned d1, input int unsigned d2);
        int unsigned exp_d [3];
        exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2;
        check({tag, "_nwr"}, ra_q.size() - base, NN);
        for (int k = 0; k < NN; k++) begin
            if (base + k < ra_q.size()) begin
                check({tag, "_res_addr"}, ra_q[base + k], k);
                check({tag, "_res_data"}, rd_q[base + k], exp_d[k]);
            end
        end
    endtask

    int de, bl, rb, ab, dc;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        quiet = 1'b0;
        start = 1'b0;
        rst   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            act_mem[k] = 16'h1000;
            b_mem[k]   = 16'h0000;
        end
        for (int k = 0; k < 16; k++) w_mem[k] = 16'h0800;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", out_vec(), 32'h0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);

        // Basic layer: 4 x (1.0 * 0.5) = 2.0 per neuron.
        rb = ra_q.size(); ab = wa_q.size(); dc = done_cnt;
        run_layer(1'b0, de, bl);
        check("done_edge", de, 19);
        check("busy_last", bl, 19);
        check("done_pulses", done_cnt - dc, 1);
        check_results("basic", rb, 16'h2000, 16'h2000, 16'h2000);
        check("npairs", wa_q.size() - ab, NN * NI);
        for (int k = 0; k < NN * NI; k++) begin
            if (ab + k < wa_q.size()) begin
                check("w_addr", wa_q[ab + k], k);
                check("in_addr", ia_q[ab + k], k % NI);
                check("b_addr", ba_q[ab + k], k / NI);
            end
        end
        check("error_clean", error, 1'b0);

        // Start held through the layer must not retrigger it.
        rb = ra_q.size(); dc = done_cnt;
        run_layer(1'b1, de, bl);
        check("hold_done_edge", de, 19);
        check("hold_done_pulses", done_cnt - dc, 1);
        check_results("hold", rb, 16'h2000, 16'h2000, 16'h2000);
        check("hold_idle", busy, 1'b0);

        // Back-to-back second layer yields the same results.
        rb = ra_q.size();
        run_layer(1'b0, de, bl);
        check("b2b_done_edge", de, 19);
        check_results("b2b", rb, 16'h2000, 16'h2000, 16'h2000);

        // Reset on the 2nd pair of neuron 1.
        rb = ra_q.size(); dc = done_cnt;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("pre_rst_valid", neu_valid, 1'b1);
        check("pre_rst_b_addr", b_addr, 2'd1);
        rst = 1'b1;
        #1;
        check("midrst_outputs", out_vec(), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_nwr", ra_q.size() - rb, 1);
        check("midrst_done", done_cnt - dc, 0);
        @(negedge clk) rst = 1'b0;
        rb = ra_q.size();
        run_layer(1'b0, de, bl);
        check("restart_done_edge", de, 19);
        check_results("restart", rb, 16'h2000, 16'h2000, 16'h2000);

        // Neuron 0 weights -1.0 -> clamped; neuron 2 gets a small bias.
        for (int k = 0; k < NI; k++) w_mem[k] = 16'hF000;
        b_mem[2] = 16'h0100;
        rb = ra_q.size();
        run_layer(1'b0, de, bl);
        check_results("neg", rb, 16'h0000, 16'h2000, 16'h2100);
        for (int k = 0; k < NI; k++) w_mem[k] = 16'h0800;
        b_mem[2] = 16'h0000;

`ifdef NEURON_LAYER_SEQ_WDOG_EN
        // Silent neuron: watchdog fires 16 cycles after WAIT entry (edge 5).
        quiet = 1'b1;
        rb = ra_q.size(); dc = done_cnt;
        run_layer(1'b0, de, bl);
        check("wdog_done_edge", de, 21);
        check("wdog_error", error, 1'b1);
        check("wdog_nwr", ra_q.size() - rb, 0);
        check("wdog_done_pulses", done_cnt - dc, 1);
        quiet = 1'b0;
        rb = ra_q.size();
        run_layer(1'b0, de, bl);
        check("wdog_clear", error, 1'b0);
        check_results("wdog_recover", rb, 16'h2000, 16'h2000, 16'h2000);
`else
        check("error_tied", error, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
